// File: rtl/dm_store_buffer_ram.sv
// dm_store_buffer_ram: M-stage data-memory array with a posted-store FIFO.
// Stores are queued and drained into the array one per cycle whenever the
// write port is free (mem_hold low). Loads merge buffered bytes on top of the
// array word, newest store winning per byte.
// Optional macro DM_WRITE_LOG_EN: keeps the PC with each buffered store and
// prints one line per drained store (simulation trace only).
module dm_store_buffer_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int SB_DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 DM_ADDR_DM,
    input  logic [31:0]                 DM_dataIN_DM,
    input  logic [3:0]                  DM_byteen_DM,
    input  logic [31:0]                 M_PC,
    input  logic                        mem_hold,
    output logic [31:0]                 M_dataOUT_DM,
    output logic                        sb_stall,
    output logic [$clog2(SB_DEPTH):0]   sb_count
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic                  wrReq;
    logic                  drain;
    logic                  accept;
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [31:0]           drainWord;
    logic [31:0]           readWord;

    // Buffer payload; validity is carried entirely by headPtr/sb_count.
    logic [ADDR_WIDTH-1:0] sbIdx  [SB_DEPTH];
    logic [31:0]           sbData [SB_DEPTH];
    logic [3:0]            sbBe   [SB_DEPTH];
`ifdef DM_WRITE_LOG_EN
    logic [31:0]           sbPc   [SB_DEPTH];
`endif

    logic [31:0]           mem [WORDS];

    // Address bits outside the word index never influence the design.
    logic unusedBits;
`ifdef DM_WRITE_LOG_EN
    assign unusedBits = ^{DM_ADDR_DM[31:ADDR_WIDTH+2], DM_ADDR_DM[1:0]};
`else
    assign unusedBits = ^{DM_ADDR_DM[31:ADDR_WIDTH+2], DM_ADDR_DM[1:0], M_PC};
`endif

    assign wordIdx  = DM_ADDR_DM[ADDR_WIDTH+1:2];
    assign wrReq    = |DM_byteen_DM;
    assign drain    = (sb_count != '0) && !mem_hold;
    // A full buffer only blocks when it cannot drain on this same edge.
    assign sb_stall = wrReq && (sb_count == CNT_W'(SB_DEPTH)) && mem_hold;
    assign accept   = wrReq && !sb_stall;

    // Merge the head entry into its current array word for the drain write.
    always_comb begin
        drainWord = mem[sbIdx[headPtr]];
        for (int b = 0; b < 4; b++) begin
            if (sbBe[headPtr][b]) begin
                drainWord[8*b +: 8] = sbData[headPtr][8*b +: 8];
            end
        end
    end

    // Load path: array word overlaid by matching entries, oldest to newest.
    always_comb begin
        logic [PTR_W-1:0] slot;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        slot     = headPtr;
        readWord = mem[wordIdx];
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = headPtr + PTR_W'(k);
            if ((CNT_W'(k) < sb_count) && (sbIdx[slot] == wordIdx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (sbBe[slot][b]) begin
                        readWord[8*b +: 8] = sbData[slot][8*b +: 8];
                    end
                end
            end
        end
    end

    assign M_dataOUT_DM = readWord;

    // Queue bookkeeping: pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            sb_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (accept) tailPtr <= tailPtr + 1'b1;
            if (drain)  headPtr <= headPtr + 1'b1;
            case ({accept, drain})
                2'b10:   sb_count <= sb_count + 1'b1;
                2'b01:   sb_count <= sb_count - 1'b1;
                default: sb_count <= sb_count;
            endcase
        end
    end

    // Capture an accepted store at the tail slot.
    // NOTE: payload is deliberately not reset; a slot is only read while sb_count marks it valid.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            sbIdx[tailPtr]  <= wordIdx;
            sbData[tailPtr] <= DM_dataIN_DM;
            sbBe[tailPtr]   <= DM_byteen_DM;
`ifdef DM_WRITE_LOG_EN
            sbPc[tailPtr]   <= M_PC;
`endif
        end
    end

    // Array: cleared on reset, one merged word written per drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is architecturally zero after reset, so this memory is reset as flops.
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (drain) begin
            mem[sbIdx[headPtr]] <= drainWord;
        end
    end

`ifdef DM_WRITE_LOG_EN
    // Trace each drained store in program order.
    always_ff @(posedge clk) begin
        if (!reset && drain) begin
            $display("%d@%h: *%h <= %h", $time, sbPc[headPtr],
                     32'({sbIdx[headPtr], 2'b00}), drainWord);
        end
    end
`endif

endmodule

// File: tb/tb_dm_store_buffer_ram.sv
// tb_dm_store_buffer_ram: directed stimulus with a queue-based reference
// model compared against the DUT on every falling edge, plus literal checks.
module tb_dm_store_buffer_ram;

    localparam int ADDR_WIDTH = 12;
    localparam int SB_DEPTH   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic        hold;
    logic [31:0] dout;
    logic        stall;
    logic [$clog2(SB_DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    dm_store_buffer_ram #(.ADDR_WIDTH(ADDR_WIDTH), .SB_DEPTH(SB_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .DM_ADDR_DM   (addr),
        .DM_dataIN_DM (wdata),
        .DM_byteen_DM (be),
        .M_PC         (pc),
        .mem_hold     (hold),
        .M_dataOUT_DM (dout),
        .sb_stall     (stall),
        .sb_count     (count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [3:0]  be;
    } store_t;

    store_t      pend[$];
    logic [31:0] mMem[int];

    function automatic int idxOf(logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << ADDR_WIDTH) - 1));
    endfunction

    function automatic logic [31:0] merge(logic [31:0] base, store_t s);
        logic [31:0] r = base;
        for (int b = 0; b < 4; b++) if (s.be[b]) r[8*b +: 8] = s.data[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] memRd(int i);
        return mMem.exists(i) ? mMem[i] : 32'h0;
    endfunction

    function automatic logic [31:0] expRead(logic [31:0] a);
        logic [31:0] r = memRd(idxOf(a));
        foreach (pend[i]) if (pend[i].idx == idxOf(a)) r = merge(r, pend[i]);
        return r;
    endfunction

    function automatic logic expStall();
        return (be != 0) && (pend.size() == SB_DEPTH) && hold;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            mMem.delete();
        end else begin
            automatic logic st  = expStall();
            automatic logic drn = (pend.size() != 0) && !hold;
            automatic store_t s;
            if (drn) begin
                s = pend.pop_front();
                mMem[s.idx] = merge(memRd(s.idx), s);
            end
            if ((be != 0) && !st) begin
                s.idx = idxOf(addr); s.data = wdata; s.be = be;
                pend.push_back(s);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("model_read",  dout, expRead(addr));
            check("model_count", 32'(count), 32'(pend.size()));
            check("model_stall", 32'(stall), 32'(expStall()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        reset = 1'b1; addr = 32'h10; wdata = '0; be = 4'b0; pc = '0; hold = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();

        // 1. reset state
        check("rst_read",  dout, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // 2. single full-word store, forwarded then drained
        addr = 32'h20; wdata = 32'h1122_3344; be = 4'b1111;
        tick();
        be = 4'b0; #1;
        check("fwd_read",  dout, 32'h1122_3344);
        check("fwd_count", 32'(count), 32'd1);
        tick();
        check("drn_count", 32'(count), 32'd0);
        check("drn_read",  dout, 32'h1122_3344);

        // 3. byte merge over an existing array word while held
        addr = 32'h30; wdata = 32'hAABB_CCDD; be = 4'b1111;
        tick();
        be = 4'b0;
        tick();
        hold = 1'b1;
        wdata = 32'h0000_0011; be = 4'b0001;
        tick();
        wdata = 32'h0022_0000; be = 4'b0100;
        tick();
        be = 4'b0; #1;
        check("merge_read",  dout, 32'hAA22_CC11);
        check("merge_count", 32'(count), 32'd2);
        hold = 1'b0;
        tick(); tick();
        check("merge_drained_cnt", 32'(count), 32'd0);
        check("merge_array",       dout, 32'hAA22_CC11);

        // 4. full buffer: stall while held, drain+enqueue once released
        hold = 1'b1; addr = 32'h50;
        wdata = 32'h0101_0101; be = 4'b1111; tick();
        wdata = 32'h0202_0202; tick();
        wdata = 32'h0303_0303; #1;
        check("full_stall", 32'(stall), 32'd1);
        check("full_count", 32'(count), 32'd2);
        tick();
        check("full_hold_count", 32'(count), 32'd2);
        check("full_hold_stall", 32'(stall), 32'd1);
        hold = 1'b0; #1;
        check("release_stall", 32'(stall), 32'd0);
        tick();
        check("swap_count", 32'(count), 32'd2);
        be = 4'b0;
        tick(); tick();
        check("order_count", 32'(count), 32'd0);
        check("order_read",  dout, 32'h0303_0303);

        // 5. asynchronous reset with entries pending
        hold = 1'b1; addr = 32'h40;
        wdata = 32'h1234_5678; be = 4'b1111; tick();
        wdata = 32'h9ABC_DEF0; be = 4'b0011; tick();
        be = 4'b0; #1;
        check("pre_rst_read",  dout, 32'h1234_DEF0);
        check("pre_rst_count", 32'(count), 32'd2);
        @(negedge clk); #1;
        reset = 1'b1; #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_read",  dout, 32'h0);
        addr = 32'h30; #1;
        check("async_rst_array", dout, 32'h0);
        tick();
        #2 reset = 1'b0; hold = 1'b0; addr = 32'h40;
        tick(); tick();
        check("post_rst_read",  dout, 32'h0);
        check("post_rst_count", 32'(count), 32'd0);

        // 6. store tagged with a PC (traced when logging is built in)
        addr = 32'h8; wdata = 32'hDEAD_BEEF; be = 4'b1111; pc = 32'h0000_3004;
        tick();
        be = 4'b0;
        tick();
        check("pc_store_read",  dout, 32'hDEAD_BEEF);
        check("pc_store_count", 32'(count), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
